// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the ALU result always wins the port, memory results
// queue in a small FIFO and drain on ALU-idle cycles, and stale queued writes are killed.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [4:0]                   alu_addr,
  input  logic [31:0]                  alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [4:0]                   mem_addr,
  input  logic [31:0]                  mem_data,
  output logic                         wr_en,
  output logic [4:0]                   wr_addr,
  output logic [31:0]                  wr_data,
  output logic [31:0]                  pending,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FIFO_DEPTH-1:0] q_live;
  logic [4:0]            q_addr [FIFO_DEPTH];
  logic [31:0]           q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic alu_sel;
  logic pop;
  logic push;
  logic push_live;
  logic head_write;

  // Port selection and FIFO handshakes; live bits of unoccupied slots are always 0
  always_comb begin
    mem_ready  = rst && (fifo_count != CNT_W'(FIFO_DEPTH));
    alu_sel    = alu_valid && (alu_addr != 5'd0);
    pop        = !alu_sel && (fifo_count != '0);
    head_write = pop && q_live[rd_ptr];
    push       = mem_valid && mem_ready && (mem_addr != 5'd0);
    push_live  = !(alu_sel && (mem_addr == alu_addr));
  end

  // Pending bitmap is a pure function of the registered queue contents
  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (q_live[i]) pending[q_addr[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_live     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      wr_en <= alu_sel || head_write;
      if (alu_sel) begin
        wr_addr <= alu_addr;
        wr_data <= alu_data;
      end else if (head_write) begin
        wr_addr <= q_addr[rd_ptr];
        wr_data <= q_data[rd_ptr];
      end

      // WAW kill of older queued writes to the ALU's destination
      if (alu_sel) begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
          if (q_addr[i] == alu_addr) q_live[i] <= 1'b0;
        end
      end

      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end

      // A same-edge ALU write to the same register makes the new entry stale on arrival
      if (push) begin
        q_live[wr_ptr] <= push_live;
        q_addr[wr_ptr] <= mem_addr;
        q_data[wr_ptr] <= mem_data;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end

      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

  localparam int unsigned D = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  writeback_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  // One clock: drive inputs, check mem_ready, advance the model at the edge, check outputs
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md);
    bit     ready_exp;
    bit     alu_win;
    entry_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    ready_exp = (mq.size() != D);
    check("mem_ready", 32'(mem_ready), 32'(ready_exp));
    @(posedge clk);
    alu_win = av && (aa != 0);
    m_wr_en = 1'b0;
    if (alu_win) begin
      m_wr_en = 1'b1; m_wr_addr = aa; m_wr_data = ad;
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin
        m_wr_en = 1'b1; m_wr_addr = e.addr; m_wr_data = e.data;
      end
    end
    if (mv && ready_exp && ma != 0) begin
      e.live = !(alu_win && ma == aa);
      e.addr = ma;
      e.data = md;
      mq.push_back(e);
    end
    #1;
    check("wr_en",      32'(wr_en),      32'(m_wr_en));
    check("wr_addr",    32'(wr_addr),    32'(m_wr_addr));
    check("wr_data",    wr_data,         m_wr_data);
    check("pending",    pending,         model_pending());
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    #3;
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_mem_ready",  32'(mem_ready),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_pending",    pending,         32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1 check("ready_after_rst", 32'(mem_ready), 32'd1);

    // ALU path, then ALU to r0 is ignored
    step(1, 5, 32'h0000_1234, 0, 0, 0);
    check("alu_wr_en",   32'(wr_en),   32'd1);
    check("alu_wr_addr", 32'(wr_addr), 32'd5);
    check("alu_wr_data", wr_data,      32'h0000_1234);
    step(1, 0, 32'hDEAD, 0, 0, 0);
    check("alu_r0_wr_en", 32'(wr_en), 32'd0);

    // Fill while the ALU is busy, then drain in order
    for (int i = 0; i < 4; i++) step(1, 20, 32'(i), 1, 5'(8 + i), 32'hA0 + 32'(i));
    check("full_ready", 32'(mem_ready),  32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    step(0, 0, 0, 0, 0, 0);
    check("drain0_addr", 32'(wr_addr), 32'd8);
    check("drain0_data", wr_data,      32'hA0);
    check("ready_after_pop", 32'(mem_ready), 32'd1);
    idle(4);

    // WAW kill of a queued write
    step(1, 20, 32'h55, 1, 7, 32'hAAAA);
    check("waw_pend_set", 32'(pending[7]), 32'd1);
    step(1, 7, 32'hBBBB, 0, 0, 0);
    check("waw_pend_clr", 32'(pending[7]), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("waw_killed_no_wr", 32'(wr_en),   32'd0);
    check("waw_last_data",    wr_data,      32'hBBBB);

    // Same-edge collision
    step(1, 12, 32'h2, 1, 12, 32'h1);
    check("coll_count",   32'(fifo_count),  32'd1);
    check("coll_pending", 32'(pending[12]), 32'd0);
    check("coll_wr_data", wr_data,          32'h2);
    idle(2);

    // Handshake to r0 is accepted and discarded
    step(0, 0, 0, 1, 0, 32'h77);
    check("r0_count", 32'(fifo_count), 32'd0);
    check("r0_wr_en", 32'(wr_en),      32'd0);

    // Reset mid-stream with queued writes to r1..r3
    for (int i = 1; i <= 3; i++) step(1, 20, 32'h9, 1, 5'(i), 32'h100 + 32'(i));
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en",   32'(wr_en),      32'd0);
    check("mid_rst_pending", pending,         32'd0);
    check("mid_rst_count",   32'(fifo_count), 32'd0);
    check("mid_rst_ready",   32'(mem_ready),  32'd0);
    model_reset();
    alu_valid = 0; mem_valid = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(5);

    // Random traffic over a small register range to provoke kills and collisions
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
